// File: rtl/spiker_pkg.sv
// rtl/spiker_pkg.sv - shared types and constants for the spike rate encoder
package spiker_pkg;

    // IDLE: waiting for a frame, GEN: advance accumulators one step,
    // PRESENT: spike vector offered to the consumer
    typedef enum logic [1:0] {
        IDLE,
        GEN,
        PRESENT
    } enc_state_t;

    // Accumulators start at half scale so that rounding is centred:
    // after k steps a channel has fired floor((2^(w-1) + k*p) / 2^w) times.
    function automatic int unsigned acc_init(input int unsigned pix_w);
        return 32'd1 << (pix_w - 1);
    endfunction

endpackage

// File: rtl/rate_channel.sv
// rtl/rate_channel.sv - one channel of rate coding: latched pixel plus phase accumulator
//
// clk, rst : clock, synchronous active-high reset
// load     : latch pix and reload the accumulator to half scale
// step     : commit acc + pix (carry dropped; it is the spike)
// pix      : pixel intensity, sampled only on load
// spike    : carry of acc + pix for the pending step (combinational)
module rate_channel
    import spiker_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [PIX_W-1:0] pix,
    output logic             spike
);

    localparam logic [PIX_W-1:0] ACC_START = PIX_W'(acc_init(PIX_W));

    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] acc_q;
    logic [PIX_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, pix_q};
    assign spike = sum[PIX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            acc_q <= '0;
        end else if (load) begin
            pix_q <= pix;
            acc_q <= ACC_START;
        end else if (step) begin
            acc_q <= sum[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - frame-to-spike-train rate encoder feeding the network stage
//
// clk, rst               : clock, synchronous active-high reset
// pix_valid/pix_ready    : frame handshake, pix_data channel i at [i*PIX_W +: PIX_W]
// sample/sample_ready    : per-step handshake, in_spikes valid while sample_ready
// frame_done             : one-cycle pulse after the last step is consumed
// busy                   : high outside IDLE
module spike_rate_encoder
    import spiker_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int PIX_W      = 8,
    parameter int N_STEPS    = 10,
    parameter int STEP_CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [N_IN*PIX_W-1:0] pix_data,
    input  logic                  sample,
    output logic                  sample_ready,
    output logic [N_IN-1:0]       in_spikes,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);

    enc_state_t            state;
    enc_state_t            next_state;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic [N_IN-1:0]       spikes_q;
    logic [N_IN-1:0]       carry;
    logic                  frame_done_q;
    logic                  load;
    logic                  step;
    logic                  consume;
    logic                  last_step;

    assign last_step = (step_cnt == LAST_STEP);

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (pix_valid) begin
                    load       = 1'b1;
                    next_state = GEN;
                end
            end
            GEN: begin
                step       = 1'b1;
                next_state = PRESENT;
            end
            PRESENT: begin
                if (sample) begin
                    consume    = 1'b1;
                    next_state = last_step ? IDLE : GEN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt     <= '0;
            spikes_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= consume && last_step;

            if (load) begin
                step_cnt <= '0;
            end else if (consume && !last_step) begin
                step_cnt <= step_cnt + 1'b1;
            end

            // Spikes are captured in GEN and held through PRESENT; the
            // vector is cleared once the final step has been taken.
            if (step) begin
                spikes_q <= carry;
            end else if (consume && last_step) begin
                spikes_q <= '0;
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        rate_channel #(
            .PIX_W (PIX_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .step  (step),
            .pix   (pix_data[i*PIX_W +: PIX_W]),
            .spike (carry[i])
        );
    end

    assign pix_ready    = (state == IDLE);
    assign sample_ready = (state == PRESENT);
    assign busy         = (state != IDLE);
    assign in_spikes    = spikes_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - directed self-checking bench for spike_rate_encoder
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_data;
    logic        sample;
    logic        sample_ready;
    logic [3:0]  in_spikes;
    logic        frame_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Hand-derived step tables, step s in nibble [4s +: 4], ch0 in bit 0.
    // Mixed {0,64,128,255}: ch3 every step, ch2 steps 1,3,5,7,9, ch1 steps 2,6,10.
    localparam logic [31:0] MIXED_PIX  = 32'hFF80_4000;
    localparam logic [39:0] MIXED_EXP  = 40'hAC8CAC8CAC;
    localparam logic [31:0] FULL_PIX   = 32'hFFFF_FFFF;
    localparam logic [39:0] FULL_EXP   = 40'hFFFFFFFFFF;
    localparam logic [31:0] HALF_PIX   = 32'h8080_8080;
    localparam logic [39:0] HALF_EXP   = 40'h0F0F0F0F0F;

    spike_rate_encoder #(
        .N_IN       (4),
        .PIX_W      (8),
        .N_STEPS    (10),
        .STEP_CNT_W (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .sample       (sample),
        .sample_ready (sample_ready),
        .in_spikes    (in_spikes),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] data);
        pix_data  = data;
        pix_valid = 1'b1;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: pix_ready=%b required 1", pix_ready);
        end
        tick();
        pix_valid = 1'b0;
        pix_data  = $urandom;
        checks++;
        if ({busy, pix_ready, sample_ready} !== 3'b100) begin
            failures++;
            $display("FAIL accept_gen: busy,pix_ready,sample_ready=%b required 100",
                     {busy, pix_ready, sample_ready});
        end
    endtask

    // Runs a frame with sample held high, entered right after send_frame.
    // pix_valid is driven with hold_data while observing steps hold_lo..hold_hi.
    task automatic run_held(input logic [39:0] exp_vec, input int hold_lo, input int hold_hi,
                            input logic [31:0] hold_data, output logic [39:0] obs);
        obs    = '0;
        sample = 1'b1;
        for (int s = 0; s < 10; s++) begin
            tick();
            pix_valid = (s + 1 >= hold_lo) && (s + 1 <= hold_hi);
            if (pix_valid) pix_data = hold_data;
            obs[s*4 +: 4] = in_spikes;
            checks++;
            if (sample_ready !== 1'b1 || in_spikes !== exp_vec[s*4 +: 4]) begin
                failures++;
                $display("FAIL step_vec[%0d]: sample_ready=%b in_spikes=%h required 1 %h",
                         s + 1, sample_ready, in_spikes, exp_vec[s*4 +: 4]);
            end
            if (pix_valid) begin
                checks++;
                if (pix_ready !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_reject[%0d]: pix_ready=%b busy=%b required 0 1",
                             s + 1, pix_ready, busy);
                end
            end
            tick();
            checks++;
            if (s == 9) begin
                if ({frame_done, pix_ready, busy, in_spikes} !== 7'b1100000) begin
                    failures++;
                    $display("FAIL frame_end: done,ready,busy,spk=%b required 1100000",
                             {frame_done, pix_ready, busy, in_spikes});
                end
            end else if ({sample_ready, frame_done, busy} !== 3'b001) begin
                failures++;
                $display("FAIL gen_gap[%0d]: sample_ready,frame_done,busy=%b required 001",
                         s + 1, {sample_ready, frame_done, busy});
            end
        end
        sample    = 1'b0;
        pix_valid = 1'b0;
        tick();
        checks++;
        if ({frame_done, pix_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL done_pulse: frame_done,pix_ready,busy=%b required 010",
                     {frame_done, pix_ready, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({pix_ready, sample_ready, in_spikes, frame_done, busy} !== 8'b10000000) begin
            failures++;
            $display("FAIL reset_idle: outputs=%b required 10000000",
                     {pix_ready, sample_ready, in_spikes, frame_done, busy});
        end
    endtask

    task automatic test_full_scale();
        logic [39:0] obs;
        send_frame(FULL_PIX);
        run_held(FULL_EXP, 0, -1, 32'h0, obs);
    endtask

    task automatic test_mixed();
        logic [39:0] obs;
        int cnt [4];
        send_frame(MIXED_PIX);
        run_held(MIXED_EXP, 0, -1, 32'h0, obs);
        for (int c = 0; c < 4; c++) begin
            cnt[c] = 0;
            for (int s = 0; s < 10; s++) cnt[c] += int'(obs[s*4 + c]);
        end
        checks++;
        if (cnt[0] != 0 || cnt[1] != 3 || cnt[2] != 5 || cnt[3] != 10) begin
            failures++;
            $display("FAIL mixed_counts: got %0d %0d %0d %0d required 0 3 5 10",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    task automatic test_backpressure();
        int          step = 0;
        logic        got_done = 1'b0;
        logic        prev_hold = 1'b0;
        logic [3:0]  prev_spk = '0;
        logic        s_bit;
        send_frame(MIXED_PIX);
        for (int c = 0; c < 600 && !got_done; c++) begin
            tick();
            if (frame_done) begin
                got_done = 1'b1;
                sample   = 1'b0;
                checks++;
                if (step != 10) begin
                    failures++;
                    $display("FAIL bp_done_step: steps=%0d required 10", step);
                end
            end else if (sample_ready) begin
                if (prev_hold) begin
                    checks++;
                    if (in_spikes !== prev_spk) begin
                        failures++;
                        $display("FAIL bp_stable: in_spikes=%h required %h", in_spikes, prev_spk);
                    end
                end
                s_bit  = 1'($urandom_range(0, 1));
                sample = s_bit;
                if (s_bit) begin
                    checks++;
                    if (step >= 10 || in_spikes !== MIXED_EXP[step*4 +: 4]) begin
                        failures++;
                        $display("FAIL bp_step[%0d]: in_spikes=%h required %h", step + 1,
                                 in_spikes, (step < 10) ? MIXED_EXP[step*4 +: 4] : 4'hx);
                    end
                    step++;
                end
                prev_hold = !s_bit;
                prev_spk  = in_spikes;
            end else begin
                sample    = 1'($urandom_range(0, 1));
                prev_hold = 1'b0;
            end
        end
        sample = 1'b0;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL bp_timeout: frame_done=0 required 1 within 600 cycles");
        end
        tick();
    endtask

    task automatic test_busy_reject();
        logic [39:0] obs;
        send_frame(FULL_PIX);
        run_held(FULL_EXP, 3, 7, MIXED_PIX, obs);
        send_frame(MIXED_PIX);
        run_held(MIXED_EXP, 0, -1, 32'h0, obs);
    endtask

    task automatic test_mid_reset();
        logic [39:0] obs;
        send_frame(HALF_PIX);
        sample = 1'b1;
        repeat (9) tick();
        checks++;
        if (sample_ready !== 1'b1 || in_spikes !== 4'hF) begin
            failures++;
            $display("FAIL mid_step5: sample_ready=%b in_spikes=%h required 1 f",
                     sample_ready, in_spikes);
        end
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        sample = 1'b0;
        checks++;
        if ({pix_ready, sample_ready, in_spikes, frame_done, busy} !== 8'b10000000) begin
            failures++;
            $display("FAIL mid_reset_idle: outputs=%b required 10000000",
                     {pix_ready, sample_ready, in_spikes, frame_done, busy});
        end
        send_frame(HALF_PIX);
        run_held(HALF_EXP, 0, -1, 32'h0, obs);
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        sample    = 1'b0;
        test_reset();
        test_full_scale();
        test_mixed();
        test_backpressure();
        test_busy_reject();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
